// File: rtl/sram_pkg.sv
// sram_pkg: shared constants for the multi-read / single-write SRAM model.
// Latency: n/a (declarations only).  Backpressure: n/a.
// Contents: clear-FSM state encodings, collision counter width/limit, RD_LAT legality helper.
package sram_pkg;

  // Clear engine states (plain constants so legacy tools can consume them).
  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_CLEAR = 1'b1;

  // Collision counter geometry.
  localparam int               COLL_W   = 16;
  localparam logic [COLL_W-1:0] COLL_MAX = 16'hFFFF;

  // Only combinational (0) or single-register (1) read latency is implemented.
  function automatic bit rd_lat_ok(input int lat);
    return (lat == 0) || (lat == 1);
  endfunction

endpackage

// File: rtl/sram_rd_port.sv
// sram_rd_port: one read port of sram_mr1w - range check, write-first forwarding, output stage.
// Latency: RD_LAT cycles (0 = combinational read-old, 1 = registered write-first).
// Backpressure: none; a request is answered unconditionally, ignored entirely while busy.
// Ports: clock/reset, busy (clear engine active), rd_en/addr (request), mem_data (array word at
//        addr), wr_ok/wr_addr/wr_data (accepted write this cycle), legal/err (request legal /
//        out of range, this cycle), data/valid (response).
module sram_rd_port
  import sram_pkg::*;
#(
  parameter int DATA_W = 128,
  parameter int ADDR_W = 16,
  parameter int DEPTH  = 256,
  parameter int RD_LAT = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              busy,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              wr_ok,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              legal,
  output logic              err,
  output logic [DATA_W-1:0] data,
  output logic              valid
);

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

  logic in_range;
  logic fwd;

  assign in_range = ({1'b0, addr} < DEPTH_L);
  assign legal    = !busy && rd_en && in_range;
  assign err      = !busy && rd_en && !in_range;
  // An accepted write to the address being read this cycle.
  assign fwd      = wr_ok && (wr_addr == addr);

  if (RD_LAT == 0) begin : g_comb
    // Read-old: the array still holds pre-write contents until the edge.
    assign valid = legal;
    assign data  = legal ? mem_data : '0;

    // Clock, reset and forwarding have no role in the combinational stage.
    logic unused_ok;
    assign unused_ok = &{1'b0, clock, reset, fwd};
  end else begin : g_reg
    always_ff @(posedge clock) begin
      if (reset) begin
        data  <= '0;
        valid <= 1'b0;
      end else if (busy) begin
        data  <= '0;
        valid <= 1'b0;
      end else if (rd_en) begin
        valid <= legal;
        // Write-first: the word being written this edge wins over the array.
        if (!legal)   data <= '0;
        else if (fwd) data <= wr_data;
        else          data <= mem_data;
      end else begin
        // No request: drop valid, keep the last returned word.
        valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/sram_mr1w.sv
// sram_mr1w: parametrised multi-read, single-write SRAM with post-reset clear engine.
// Latency: writes land at the clock edge; reads take RD_LAT cycles (0 or 1).
// Backpressure: busy is high while the clear engine runs; all accesses are then ignored.
// Ports: clock, reset (sync, active-high); WE/WriteAddress/WriteBus (write port);
//        rd_en/ReadAddress (NUM_RD packed requests); ReadBus/ReadValid (NUM_RD packed responses);
//        busy (clear running); addr_err (sticky out-of-range flag); coll_count (saturating
//        count of cycles where an accepted write hit a legal read address).
module sram_mr1w
  import sram_pkg::*;
#(
  parameter int DATA_W         = 128,
  parameter int ADDR_W         = 16,
  parameter int DEPTH          = 256,
  parameter int NUM_RD         = 2,
  parameter int RD_LAT         = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     WE,
  input  logic [ADDR_W-1:0]        WriteAddress,
  input  logic [DATA_W-1:0]        WriteBus,
  input  logic [NUM_RD-1:0]        rd_en,
  input  logic [NUM_RD*ADDR_W-1:0] ReadAddress,
  output logic [NUM_RD*DATA_W-1:0] ReadBus,
  output logic [NUM_RD-1:0]        ReadValid,
  output logic                     busy,
  output logic                     addr_err,
  output logic [COLL_W-1:0]        coll_count
);

  // Index width of the implemented array; addresses are range-checked before use.
  localparam int              IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_L   = (ADDR_W+1)'(DEPTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);
  localparam logic [0:0]      RST_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;

  if (!rd_lat_ok(RD_LAT)) begin : g_bad_rd_lat
    $error("sram_mr1w: RD_LAT must be 0 or 1");
  end

  // Storage; named Register so the system bench can reach it hierarchically.
  logic [DATA_W-1:0] Register [0:DEPTH-1];

  logic [0:0]       state;
  logic [IDX_W-1:0] ptr;

  logic              wr_in_range;
  logic              wr_ok;
  logic [ADDR_W-1:0] rd_addr  [NUM_RD];
  logic [DATA_W-1:0] rd_mem   [NUM_RD];
  logic [NUM_RD-1:0] rd_legal;
  logic [NUM_RD-1:0] rd_err;
  logic [NUM_RD-1:0] rd_match;
  logic              coll_hit;

  assign busy        = (state == ST_CLEAR);
  assign wr_in_range = ({1'b0, WriteAddress} < DEPTH_L);
  assign wr_ok       = !busy && WE && wr_in_range;

  // ------------------------------------------------------------------
  // Clear engine: one word per edge, DEPTH edges after reset release.
  // Reset mid-clear simply restarts from word 0.
  // ------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= RST_STATE;
      ptr   <= '0;
    end else if (state == ST_CLEAR) begin
      if (ptr == LAST_IDX) begin
        state <= ST_IDLE;
        ptr   <= '0;
      end else begin
        ptr <= ptr + 1'b1;
      end
    end
  end

  // ------------------------------------------------------------------
  // Array write: clear engine and user port are mutually exclusive via busy.
  // Reset itself never touches the contents.
  // ------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (!reset) begin
      if (busy) begin
        Register[ptr] <= '0;
      end else if (wr_ok) begin
        Register[WriteAddress[IDX_W-1:0]] <= WriteBus;
      end
    end
  end

  // ------------------------------------------------------------------
  // Read ports
  // ------------------------------------------------------------------
  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    assign rd_addr[i]  = ReadAddress[i*ADDR_W +: ADDR_W];
    // Out-of-range addresses alias here, but the port discards that word.
    assign rd_mem[i]   = Register[rd_addr[i][IDX_W-1:0]];
    assign rd_match[i] = rd_legal[i] && (rd_addr[i] == WriteAddress);

    sram_rd_port #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .DEPTH  (DEPTH),
      .RD_LAT (RD_LAT)
    ) u_rd_port (
      .clock    (clock),
      .reset    (reset),
      .busy     (busy),
      .rd_en    (rd_en[i]),
      .addr     (rd_addr[i]),
      .mem_data (rd_mem[i]),
      .wr_ok    (wr_ok),
      .wr_addr  (WriteAddress),
      .wr_data  (WriteBus),
      .legal    (rd_legal[i]),
      .err      (rd_err[i]),
      .data     (ReadBus[i*DATA_W +: DATA_W]),
      .valid    (ReadValid[i])
    );
  end

  // One collision per cycle no matter how many ports hit the write address.
  assign coll_hit = wr_ok && (|rd_match);

  // ------------------------------------------------------------------
  // Status: sticky range error and saturating collision counter.
  // ------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      addr_err <= 1'b0;
    end else if (!busy && ((WE && !wr_in_range) || (|rd_err))) begin
      addr_err <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      coll_count <= '0;
    end else if (coll_hit && (coll_count != COLL_MAX)) begin
      coll_count <= coll_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_sram_mr1w.sv
// tb_sram_mr1w: two instances - A (RD_LAT=1, clear on reset) and B (RD_LAT=0, keep contents).
// Expected read data is queued per port when a request is issued; a negedge monitor pops and
// compares whenever ReadValid is seen. Status outputs are compared directly after edges.
module tb_sram_mr1w;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  // Instance A signals
  logic        a_reset, a_we;
  logic [7:0]  a_waddr;
  logic [31:0] a_wbus;
  logic [1:0]  a_rd_en;
  logic [15:0] a_raddr;
  logic [63:0] a_rbus;
  logic [1:0]  a_rvalid;
  logic        a_busy, a_err;
  logic [15:0] a_coll;

  // Instance B signals
  logic        b_reset, b_we;
  logic [7:0]  b_waddr;
  logic [31:0] b_wbus;
  logic [1:0]  b_rd_en;
  logic [15:0] b_raddr;
  logic [63:0] b_rbus;
  logic [1:0]  b_rvalid;
  logic        b_busy, b_err;
  logic [15:0] b_coll;

  sram_mr1w #(
    .DATA_W(32), .ADDR_W(8), .DEPTH(16), .NUM_RD(2), .RD_LAT(1), .CLEAR_ON_RESET(1)
  ) dut_a (
    .clock(clock), .reset(a_reset), .WE(a_we), .WriteAddress(a_waddr), .WriteBus(a_wbus),
    .rd_en(a_rd_en), .ReadAddress(a_raddr), .ReadBus(a_rbus), .ReadValid(a_rvalid),
    .busy(a_busy), .addr_err(a_err), .coll_count(a_coll)
  );

  sram_mr1w #(
    .DATA_W(32), .ADDR_W(8), .DEPTH(16), .NUM_RD(2), .RD_LAT(0), .CLEAR_ON_RESET(0)
  ) dut_b (
    .clock(clock), .reset(b_reset), .WE(b_we), .WriteAddress(b_waddr), .WriteBus(b_wbus),
    .rd_en(b_rd_en), .ReadAddress(b_raddr), .ReadBus(b_rbus), .ReadValid(b_rvalid),
    .busy(b_busy), .addr_err(b_err), .coll_count(b_coll)
  );

  int total = 0;
  int bad   = 0;

  logic [31:0] qa0[$];
  logic [31:0] qa1[$];
  logic [31:0] qb0[$];
  logic [31:0] qb1[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Monitor: pop and compare whenever a port presents valid data.
  always @(negedge clock) begin
    if (a_rvalid[0] === 1'b1) begin
      if (qa0.size() == 0) check("a0 unexpected valid", 32'(a_rvalid[0]), 32'd0);
      else                 check("a0 data", a_rbus[31:0], qa0.pop_front());
    end
    if (a_rvalid[1] === 1'b1) begin
      if (qa1.size() == 0) check("a1 unexpected valid", 32'(a_rvalid[1]), 32'd0);
      else                 check("a1 data", a_rbus[63:32], qa1.pop_front());
    end
    if (b_rvalid[0] === 1'b1) begin
      if (qb0.size() == 0) check("b0 unexpected valid", 32'(b_rvalid[0]), 32'd0);
      else                 check("b0 data", b_rbus[31:0], qb0.pop_front());
    end
    if (b_rvalid[1] === 1'b1) begin
      if (qb1.size() == 0) check("b1 unexpected valid", 32'(b_rvalid[1]), 32'd0);
      else                 check("b1 data", b_rbus[63:32], qb1.pop_front());
    end
  end

  initial begin
    int n;
    a_reset = 1'b1; a_we = 1'b0; a_waddr = '0; a_wbus = '0; a_rd_en = '0; a_raddr = '0;
    b_reset = 1'b1; b_we = 1'b0; b_waddr = '0; b_wbus = '0; b_rd_en = '0; b_raddr = '0;
    tick();
    tick();

    // Reset state
    check("a reset busy",  32'(a_busy), 32'd1);
    check("a reset valid", 32'(a_rvalid), 32'd0);
    check("a reset rbus",  a_rbus[31:0], 32'd0);
    check("a reset err",   32'(a_err), 32'd0);
    check("a reset coll",  32'(a_coll), 32'd0);
    check("b reset busy",  32'(b_busy), 32'd0);
    a_reset = 1'b0;
    b_reset = 1'b0;

    // Clear window: accesses (write @0, reads @0 and @16) must all be ignored.
    a_we = 1'b1; a_waddr = 8'd0; a_wbus = 32'hFFFF_FFFF;
    a_rd_en = 2'b11; a_raddr = {8'd16, 8'd0};
    n = 0;
    while (a_busy && n < 100) begin
      check("a valid during busy", 32'(a_rvalid), 32'd0);
      tick();
      n++;
    end
    check("a busy cycles", 32'(n), 32'd16);
    a_we = 1'b0; a_rd_en = 2'b00;
    check("a err after busy",  32'(a_err), 32'd0);
    check("a coll after busy", 32'(a_coll), 32'd0);
    check("a rbus after busy", a_rbus[31:0], 32'd0);

    // Every word reads zero after the clear.
    for (int a = 0; a < 16; a++) begin
      a_rd_en = 2'b11;
      a_raddr = {8'(15 - a), 8'(a)};
      qa0.push_back(32'd0);
      qa1.push_back(32'd0);
      tick();
    end
    a_rd_en = 2'b00;
    tick();

    // Write then dual-port read of the same word.
    a_we = 1'b1; a_waddr = 8'd3; a_wbus = 32'hDEAD_BEEF;
    tick();
    a_we = 1'b0; a_rd_en = 2'b11; a_raddr = {8'd3, 8'd3};
    qa0.push_back(32'hDEAD_BEEF);
    qa1.push_back(32'hDEAD_BEEF);
    tick();
    a_rd_en = 2'b00;
    check("a dual read valid", 32'(a_rvalid), 32'd3);
    tick();

    // Same-cycle write/read: write-first forwarding, one collision.
    a_we = 1'b1; a_waddr = 8'd5; a_wbus = 32'h1234_5678;
    a_rd_en = 2'b01; a_raddr = {8'd0, 8'd5};
    qa0.push_back(32'h1234_5678);
    tick();
    a_we = 1'b0; a_rd_en = 2'b00;
    check("a coll single", 32'(a_coll), 32'd1);
    tick();

    // Both ports hit the write address: still counts once.
    a_we = 1'b1; a_waddr = 8'd7; a_wbus = 32'hA5A5_A5A5;
    a_rd_en = 2'b11; a_raddr = {8'd7, 8'd7};
    qa0.push_back(32'hA5A5_A5A5);
    qa1.push_back(32'hA5A5_A5A5);
    tick();
    a_we = 1'b0; a_rd_en = 2'b00;
    check("a coll two ports", 32'(a_coll), 32'd2);
    tick();

    // Later readback of @5 on port1.
    a_rd_en = 2'b10; a_raddr = {8'd5, 8'd0};
    qa1.push_back(32'h1234_5678);
    tick();
    a_rd_en = 2'b00;
    tick();

    // Out-of-range write @20 and read @16.
    a_we = 1'b1; a_waddr = 8'd20; a_wbus = 32'hBAD0_BAD0;
    a_rd_en = 2'b10; a_raddr = {8'd16, 8'd0};
    tick();
    a_we = 1'b0; a_rd_en = 2'b00;
    check("a oor valid", 32'(a_rvalid), 32'd0);
    check("a oor rbus1", a_rbus[63:32], 32'd0);
    check("a oor err",   32'(a_err), 32'd1);
    check("a oor coll",  32'(a_coll), 32'd2);
    // @20 must not alias onto @4.
    a_rd_en = 2'b01; a_raddr = {8'd0, 8'd4};
    qa0.push_back(32'd0);
    tick();
    a_rd_en = 2'b00;
    repeat (3) tick();
    check("a err sticky", 32'(a_err), 32'd1);

    // Reset in the middle of the clear restarts it.
    a_reset = 1'b1;
    tick();
    a_reset = 1'b0;
    repeat (7) tick();
    check("a busy mid clear", 32'(a_busy), 32'd1);
    a_reset = 1'b1;
    tick();
    check("a err cleared",  32'(a_err), 32'd0);
    check("a coll cleared", 32'(a_coll), 32'd0);
    a_reset = 1'b0;
    n = 0;
    while (a_busy && n < 100) begin
      tick();
      n++;
    end
    check("a busy after restart", 32'(n), 32'd16);
    a_rd_en = 2'b11; a_raddr = {8'd7, 8'd3};
    qa0.push_back(32'd0);
    qa1.push_back(32'd0);
    tick();
    a_rd_en = 2'b00;
    tick();

    // Collision counter saturation.
    a_we = 1'b1; a_waddr = 8'd1;
    a_rd_en = 2'b01; a_raddr = {8'd0, 8'd1};
    for (int i = 0; i < 70000; i++) begin
      a_wbus = 32'(i);
      qa0.push_back(32'(i));
      tick();
    end
    a_we = 1'b0; a_rd_en = 2'b00;
    tick();
    check("a coll saturate", 32'(a_coll), 32'h0000_FFFF);

    // ---------------- Instance B: RD_LAT=0, contents kept over reset ----------------
    b_we = 1'b1; b_waddr = 8'd2; b_wbus = 32'h55AA_55AA;
    tick();
    b_waddr = 8'd5; b_wbus = 32'h0BAD_F00D;
    tick();
    b_we = 1'b0;
    b_reset = 1'b1;
    tick();
    b_reset = 1'b0;
    check("b err after reset", 32'(b_err), 32'd0);
    n = 0;
    repeat (20) begin
      if (b_busy) n++;
      tick();
    end
    check("b busy cycles", 32'(n), 32'd0);

    // Preloaded word survives reset; both ports same address, same cycle.
    b_rd_en = 2'b11; b_raddr = {8'd2, 8'd2};
    qb0.push_back(32'h55AA_55AA);
    qb1.push_back(32'h55AA_55AA);
    #1;
    check("b comb valid", 32'(b_rvalid), 32'd3);
    tick();
    b_rd_en = 2'b00;

    // Same-cycle write/read returns the old contents.
    b_we = 1'b1; b_waddr = 8'd5; b_wbus = 32'h1234_5678;
    b_rd_en = 2'b01; b_raddr = {8'd0, 8'd5};
    qb0.push_back(32'h0BAD_F00D);
    tick();
    b_we = 1'b0; b_rd_en = 2'b00;
    check("b coll", 32'(b_coll), 32'd1);
    b_rd_en = 2'b10; b_raddr = {8'd5, 8'd0};
    qb1.push_back(32'h1234_5678);
    tick();
    b_rd_en = 2'b00;

    // Illegal combinational read.
    b_rd_en = 2'b10; b_raddr = {8'd16, 8'd0};
    #1;
    check("b oor valid", 32'(b_rvalid), 32'd0);
    check("b oor rbus1", b_rbus[63:32], 32'd0);
    tick();
    b_rd_en = 2'b00;
    check("b oor err", 32'(b_err), 32'd1);
    tick();

    // Every queued response must have been seen.
    check("qa0 drained", 32'(qa0.size()), 32'd0);
    check("qa1 drained", 32'(qa1.size()), 32'd0);
    check("qb0 drained", 32'(qb0.size()), 32'd0);
    check("qb1 drained", 32'(qb1.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
